// File: rtl/ring_pos_from_remote_receiver.sv
// Receive side of the inter-node position path: validates remote packets and queues them.
// Define POS_RX_SRC_COUNT_EN to build per-source stored-packet counters.
module ring_pos_from_remote_receiver #(
  parameter int AXIS_PKT_STRUCT_WIDTH = 256,
  parameter int NODE_ID_WIDTH         = 3,
  parameter int NUM_REMOTE_SRC_NODES  = 7,
  parameter int FIFO_DEPTH            = 16,
  parameter int CNT_WIDTH             = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NODE_ID_WIDTH-1:0]                  i_init_id,
  input  logic                                      i_start,
  input  logic [AXIS_PKT_STRUCT_WIDTH-1:0]          i_axis_pos_pkt_from_remote,
  input  logic                                      i_rd_en,
  output logic [AXIS_PKT_STRUCT_WIDTH-3:0]          o_pos_pkt,
  output logic                                      o_pos_pkt_valid,
  output logic                                      o_buf_empty,
  output logic [NUM_REMOTE_SRC_NODES-1:0]           o_last_pos_received,
  output logic                                      o_all_last_received,
  output logic [CNT_WIDTH-1:0]                      o_rx_count,
  output logic [7:0]                                o_drop_count,
  output logic [7:0]                                o_err_count,
  output logic [NUM_REMOTE_SRC_NODES*CNT_WIDTH-1:0] o_src_pkt_count
);

  localparam int W   = AXIS_PKT_STRUCT_WIDTH;
  localparam int PLW = W - 5;
  localparam int OW  = PLW + 3;
  localparam int NR  = NUM_REMOTE_SRC_NODES;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic                     pkt_valid;
  logic [NODE_ID_WIDTH-1:0] src_id;
  logic                     pkt_last;
  logic [PLW-1:0]           payload;
  logic [NODE_ID_WIDTH-1:0] delta;
  logic [2:0]               src_idx;
  logic [NR-1:0]            src_bit;

  assign pkt_valid = i_axis_pos_pkt_from_remote[W-1];
  assign src_id    = i_axis_pos_pkt_from_remote[W-2:W-4];
  assign pkt_last  = i_axis_pos_pkt_from_remote[W-5];
  assign payload   = i_axis_pos_pkt_from_remote[PLW-1:0];
  assign delta     = i_init_id ^ src_id;
  assign src_idx   = 3'd7 - delta;
  assign src_bit   = NR'(1) << src_idx;

  logic [NR-1:0]        flags, flags_base, flags_nxt;
  logic [CNT_WIDTH-1:0] rx_cnt, rx_base, rx_nxt;
  logic [7:0]           drop_cnt, err_cnt;
  logic                 start_clr, rx_active, legal;
  logic                 dup, err_ev;

  logic [OW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;

  // A start in IDLE/DONE opens the iteration in the same cycle it arrives
  assign start_clr = i_start & ((state == IDLE) | (state == DONE));
  assign rx_active = (state == RECV) | start_clr;
  assign legal     = pkt_valid & rx_active & (delta != '0);

  assign flags_base = start_clr ? '0 : flags;
  assign dup        = legal & pkt_last & |(flags_base & src_bit);
  assign err_ev     = (pkt_valid & ~legal) | dup;
  assign flags_nxt  = flags_base | ((legal & pkt_last) ? src_bit : '0);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = i_rd_en & ~empty;
  assign push  = legal & (~full | pop);
  assign drop  = legal & full & ~pop;

  assign rx_base = start_clr ? '0 : rx_cnt;
  assign rx_nxt  = (push && rx_base != '1) ? rx_base + 1'b1 : rx_base;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start) state_nxt = RECV;
      RECV:    if (&flags_nxt) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    if (i_start) state_nxt = RECV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      flags    <= '0;
      rx_cnt   <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state  <= state_nxt;
      flags  <= flags_nxt;
      rx_cnt <= rx_nxt;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      if (err_ev && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array carries no reset; the empty flag masks stale data
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {src_idx, payload};
  end

`ifdef POS_RX_SRC_COUNT_EN
  logic [CNT_WIDTH-1:0] src_cnt     [NR];
  logic [CNT_WIDTH-1:0] src_cnt_nxt [NR];

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      src_cnt_nxt[k] = start_clr ? '0 : src_cnt[k];
      if (push && src_bit[k] && src_cnt_nxt[k] != '1)
        src_cnt_nxt[k] = src_cnt_nxt[k] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) src_cnt[k] <= '0;
    end else begin
      src_cnt <= src_cnt_nxt;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_src
    assign o_src_pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = src_cnt[g];
  end
`else
  assign o_src_pkt_count = '0;
`endif

  assign o_pos_pkt           = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_pos_pkt_valid     = ~empty;
  assign o_buf_empty         = empty;
  assign o_last_pos_received = flags;
  assign o_all_last_received = (state == DONE);
  assign o_rx_count          = rx_cnt;
  assign o_drop_count        = drop_cnt;
  assign o_err_count         = err_cnt;

endmodule

// File: tb/tb_ring_pos_from_remote_receiver.sv
// Directed bench for ring_pos_from_remote_receiver.
// Expected values are hand-derived from the packet sequences.
module tb_ring_pos_from_remote_receiver;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   i_init_id = 3'd0;
  logic         i_start = 1'b0;
  logic [255:0] pkt = '0;
  logic         i_rd_en = 1'b0;
  logic [253:0] o_pos_pkt;
  logic         o_pos_pkt_valid;
  logic         o_buf_empty;
  logic [6:0]   o_last_pos_received;
  logic         o_all_last_received;
  logic [15:0]  o_rx_count;
  logic [7:0]   o_drop_count;
  logic [7:0]   o_err_count;
  logic [111:0] o_src_pkt_count;

  int n_chk = 0;
  int n_fail = 0;

  ring_pos_from_remote_receiver dut (
    .clk                        (clk),
    .rst                        (rst),
    .i_init_id                  (i_init_id),
    .i_start                    (i_start),
    .i_axis_pos_pkt_from_remote (pkt),
    .i_rd_en                    (i_rd_en),
    .o_pos_pkt                  (o_pos_pkt),
    .o_pos_pkt_valid            (o_pos_pkt_valid),
    .o_buf_empty                (o_buf_empty),
    .o_last_pos_received        (o_last_pos_received),
    .o_all_last_received        (o_all_last_received),
    .o_rx_count                 (o_rx_count),
    .o_drop_count               (o_drop_count),
    .o_err_count                (o_err_count),
    .o_src_pkt_count            (o_src_pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic v, input logic [2:0] id,
                                      input logic l, input logic [250:0] pl);
    return {v, id, l, pl};
  endfunction

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt = '0;
    i_start = 1'b0;
    i_rd_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  logic [2:0]   idxq [$];
  logic [250:0] lastp;
  int           n;
  bit           seen_done;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_pkt", o_pos_pkt, 0);
    check("rst_valid", o_pos_pkt_valid, 0);
    check("rst_empty", o_buf_empty, 1);
    check("rst_all_last", o_all_last_received, 0);
    check("rst_flags", o_last_pos_received, 0);
    check("rst_cnts", {o_rx_count, o_drop_count, o_err_count}, 0);

    // packet while IDLE is an error
    pkt = mk(1, 3'd1, 0, 251'd7);
    tick();
    pkt = '0;
    tick();
    check("idle_err", o_err_count, 1);
    check("idle_empty", o_buf_empty, 1);
    check("idle_rx", o_rx_count, 0);

    // full iteration, one last packet from each neighbour
    do_reset();
    i_init_id = 3'b000;
    i_start = 1;
    tick();
    i_start = 0;
    i_rd_en = 1;
    idxq.delete();
    seen_done = 0;
    for (int k = 0; k < 14; k++) begin
      pkt = (k < 7) ? mk(1, 3'(k + 1), 1, 251'(k)) : '0;
      tick();
      if (o_pos_pkt_valid) idxq.push_back(o_pos_pkt[253:251]);
      if (o_all_last_received && !seen_done) begin
        seen_done = 1;
        check("s1_empty_at_done", o_buf_empty, 1);
      end
    end
    check("s1_npkts", idxq.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < idxq.size())
        check($sformatf("s1_idx%0d", i), idxq[i], 6 - i);
    check("s1_done", seen_done, 1);
    check("s1_rx", o_rx_count, 7);
    check("s1_flags", o_last_pos_received, 7'h7f);
    check("s1_err", o_err_count, 0);

    // start in DONE together with a packet
    i_rd_en = 0;
    i_start = 1;
    pkt = mk(1, 3'd2, 1, 251'h55);
    tick();
    i_start = 0;
    pkt = '0;
    check("s4_flags", o_last_pos_received, 7'b0100000);
    check("s4_rx", o_rx_count, 1);
    check("s4_valid", o_pos_pkt_valid, 1);
    check("s4_idx", o_pos_pkt[253:251], 5);
    check("s4_payload", o_pos_pkt[250:0], 251'h55);
    check("s4_not_done", o_all_last_received, 0);

    // own-ID packet is rejected
    do_reset();
    i_init_id = 3'b101;
    i_start = 1;
    tick();
    i_start = 0;
    pkt = mk(1, 3'b101, 0, 251'd9);
    tick();
    pkt = '0;
    check("s2_err", o_err_count, 1);
    check("s2_empty", o_buf_empty, 1);
    check("s2_rx", o_rx_count, 0);
    pkt = mk(1, 3'b100, 0, 251'd3);
    tick();
    pkt = '0;
    check("s2_idx", o_pos_pkt[253:251], 6);
    check("s2_err2", o_err_count, 1);

    // overflow: 18 pushes into 16 entries
    do_reset();
    i_init_id = 3'b000;
    i_start = 1;
    tick();
    i_start = 0;
    for (int k = 0; k < 18; k++) begin
      pkt = mk(1, 3'b001, 0, 251'(k));
      tick();
    end
    pkt = '0;
    check("s3_rx", o_rx_count, 16);
    check("s3_drop", o_drop_count, 2);
    check("s3_valid", o_pos_pkt_valid, 1);
    check("s3_head", o_pos_pkt[250:0], 0);
    pkt = mk(1, 3'b001, 0, 251'd100);
    i_rd_en = 1;
    tick();
    pkt = '0;
    check("s3_rx_pp", o_rx_count, 17);
    check("s3_drop_pp", o_drop_count, 2);
    check("s3_head_pp", o_pos_pkt[250:0], 1);
    n = 0;
    lastp = '0;
    for (int k = 0; k < 20; k++) begin
      if (o_pos_pkt_valid) begin
        n++;
        lastp = o_pos_pkt[250:0];
      end
      tick();
    end
    check("s3_occupancy", n, 16);
    check("s3_tail", lastp, 100);
    check("s3_empty", o_buf_empty, 1);
    i_rd_en = 0;

    // duplicate last, then async reset mid-iteration
    do_reset();
    i_start = 1;
    tick();
    i_start = 0;
    for (int k = 0; k < 5; k++) begin
      pkt = mk(1, 3'b011, (k >= 3), 251'(k));
      tick();
    end
    pkt = '0;
    check("s5_dup_err", o_err_count, 1);
    check("s5_rx", o_rx_count, 5);
    check("s5_flags", o_last_pos_received, 7'b0010000);
    check("s5_valid", o_pos_pkt_valid, 1);
    #2;
    rst = 1;
    #1;
    check("s5_rst_empty", o_buf_empty, 1);
    check("s5_rst_valid", o_pos_pkt_valid, 0);
    check("s5_rst_pkt", o_pos_pkt, 0);
    check("s5_rst_flags", o_last_pos_received, 0);
    check("s5_rst_cnts", {o_rx_count, o_drop_count, o_err_count}, 0);
    check("s5_rst_done", o_all_last_received, 0);
    check("s5_rst_src", o_src_pkt_count, 0);
    #3;
    rst = 0;
    tick();
    pkt = mk(1, 3'b011, 0, 251'd1);
    tick();
    pkt = '0;
    check("s5_idle_err", o_err_count, 1);
    check("s5_idle_empty", o_buf_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
